// File: rtl/alu_pkg.sv
// Shared types for the ALU stage: operation codes and FSM states.
// Optional macro ALU_OVERFLOW_EN (used by alu_stage/alu_stage_if) adds flag_overflow.
package alu_pkg;

    typedef enum logic [1:0] {
        ADD    = 2'd0,
        SUB    = 2'd1,
        ADC    = 2'd2,
        PASS_B = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/alu_stage_if.sv
// Operand bus, operation handshake and result handshake for alu_stage.
// With ALU_OVERFLOW_EN defined the flag_overflow signal is present.
interface alu_stage_if;
    import alu_pkg::*;

    logic [7:0] bus_in;
    logic       load_a;
    logic       load_b;
    logic       op_valid;
    logic       op_ready;
    op_e        op_code;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] result;
    logic       flag_carry;
    logic       flag_zero;
`ifdef ALU_OVERFLOW_EN
    logic       flag_overflow;
`endif

    modport master (
        output bus_in, load_a, load_b, op_valid, op_code, res_ready,
`ifdef ALU_OVERFLOW_EN
        input  flag_overflow,
`endif
        input  op_ready, res_valid, result, flag_carry, flag_zero
    );

    modport slave (
        input  bus_in, load_a, load_b, op_valid, op_code, res_ready,
`ifdef ALU_OVERFLOW_EN
        output flag_overflow,
`endif
        output op_ready, res_valid, result, flag_carry, flag_zero
    );

endinterface

// File: rtl/adder8.sv
// 8-bit adder with carry in/out; the single carry chain of the ALU stage.
module adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};

endmodule

// File: rtl/alu_stage.sv
// Three-state (IDLE/EXEC/HOLD) 8-bit ALU stage with operand registers and handshakes.
// Define ALU_OVERFLOW_EN to add the registered signed-overflow flag.
module alu_stage
    import alu_pkg::*;
#(
    parameter logic [7:0] RESET_A = 8'h00,
    parameter logic [7:0] RESET_B = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    alu_stage_if.slave  bus
);

    state_e     state;
    logic [7:0] reg_a;
    logic [7:0] reg_b;
    logic [7:0] opnd_a;
    logic [7:0] opnd_b;
    op_e        op_q;
    logic [7:0] result_q;
    logic       carry_q;
    logic       zero_q;
    logic       ready_q;
    logic       valid_q;

    logic [7:0] b_eff;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic [7:0] result_n;
    logic       carry_n;

    always_comb begin
        b_eff = (op_q == SUB) ? ~opnd_b : opnd_b;
        cin   = 1'b0;
        if (op_q == SUB)
            cin = 1'b1;
        else if (op_q == ADC)
            cin = carry_q;
    end

    adder8 u_adder (
        .a    (opnd_a),
        .b    (b_eff),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    always_comb begin
        result_n = sum;
        carry_n  = cout;
        if (op_q == PASS_B) begin
            result_n = opnd_b;
            carry_n  = 1'b0;
        end
    end

`ifdef ALU_OVERFLOW_EN
    logic overflow_q;
    logic overflow_n;

    always_comb begin
        overflow_n = (opnd_a[7] == b_eff[7]) && (sum[7] != opnd_a[7]) && (op_q != PASS_B);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overflow_q <= 1'b0;
        else if (state == EXEC)
            overflow_q <= overflow_n;
    end

    assign bus.flag_overflow = overflow_q;
`endif

    // Operands are snapshotted at accept so a load on the same edge does not leak into the op.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            reg_a    <= RESET_A;
            reg_b    <= RESET_B;
            opnd_a   <= '0;
            opnd_b   <= '0;
            op_q     <= ADD;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load_a)
                        reg_a <= bus.bus_in;
                    if (bus.load_b)
                        reg_b <= bus.bus_in;
                    if (bus.op_valid && ready_q) begin
                        opnd_a  <= reg_a;
                        opnd_b  <= reg_b;
                        op_q    <= bus.op_code;
                        ready_q <= 1'b0;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    result_q <= result_n;
                    carry_q  <= carry_n;
                    zero_q   <= (result_n == 8'h00);
                    valid_q  <= 1'b1;
                    state    <= HOLD;
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.op_ready   = ready_q;
    assign bus.res_valid  = valid_q;
    assign bus.result     = result_q;
    assign bus.flag_carry = carry_q;
    assign bus.flag_zero  = zero_q;

endmodule

// File: tb/tb_alu_stage.sv
// Directed self-checking bench for alu_stage with an arithmetic reference model.
// Overflow checks are compiled in when ALU_OVERFLOW_EN is defined.
module tb_alu_stage;
    import alu_pkg::*;

    localparam logic [7:0] RA = 8'h3C;
    localparam logic [7:0] RB = 8'h11;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    alu_stage_if intf ();

    alu_stage #(.RESET_A(RA), .RESET_B(RB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (intf)
    );

    always #5 clk = ~clk;

    // Reference model: operand values, phase of the current operation, expected outputs.
    int   ma = int'(RA), mb = int'(RB);
    int   pa = 0, pb = 0, pc = 0;
    op_e  pop = ADD;
    int   phase = 0;
    int   mres = 0, mc = 0, mz = 0, mv = 0;
    int   full = 0, sa = 0, sb = 0, ssum = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ma = int'(RA); mb = int'(RB);
            mres = 0; mc = 0; mz = 0; mv = 0; phase = 0;
        end else if (phase == 0) begin
            if (intf.op_valid) begin
                pa = ma; pb = mb; pc = mc; pop = intf.op_code; phase = 1;
            end
            if (intf.load_a) ma = int'(intf.bus_in);
            if (intf.load_b) mb = int'(intf.bus_in);
        end else if (phase == 1) begin
            sa = (pa > 127) ? pa - 256 : pa;
            sb = (pb > 127) ? pb - 256 : pb;
            case (pop)
                ADD:     begin full = pa + pb;             ssum = sa + sb;      end
                SUB:     begin full = pa + (255 - pb) + 1; ssum = sa - sb;      end
                ADC:     begin full = pa + pb + pc;        ssum = sa + sb + pc; end
                default: begin full = pb;                  ssum = 0;            end
            endcase
            mres  = full % 256;
            mc    = (pop != PASS_B && full > 255) ? 1 : 0;
            mz    = (mres == 0) ? 1 : 0;
            mv    = (ssum > 127 || ssum < -128) ? 1 : 0;
            phase = 2;
        end else if (intf.res_ready) begin
            phase = 0;
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("m_op_ready", {7'b0, intf.op_ready}, (phase == 0) ? 8'd1 : 8'd0);
            chk("m_res_valid", {7'b0, intf.res_valid}, (phase == 2) ? 8'd1 : 8'd0);
            chk("m_result", intf.result, 8'(mres));
            chk("m_carry", {7'b0, intf.flag_carry}, 8'(mc));
            chk("m_zero", {7'b0, intf.flag_zero}, 8'(mz));
`ifdef ALU_OVERFLOW_EN
            chk("m_overflow", {7'b0, intf.flag_overflow}, 8'(mv));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b);
        intf.bus_in = a; intf.load_a = 1'b1;
        step();
        intf.load_a = 1'b0; intf.bus_in = b; intf.load_b = 1'b1;
        step();
        intf.load_b = 1'b0;
    endtask

    task automatic do_op(input string name, input op_e op, input logic [7:0] er,
                         input logic ec, input logic ez, input logic ev);
        intf.op_code = op; intf.op_valid = 1'b1;
        step();
        intf.op_valid = 1'b0; intf.load_a = 1'b0; intf.load_b = 1'b0;
        chk({name, "_exec_valid"}, {7'b0, intf.res_valid}, 8'd0);
        chk({name, "_exec_ready"}, {7'b0, intf.op_ready}, 8'd0);
        step();
        chk({name, "_valid"}, {7'b0, intf.res_valid}, 8'd1);
        chk({name, "_result"}, intf.result, er);
        chk({name, "_carry"}, {7'b0, intf.flag_carry}, {7'b0, ec});
        chk({name, "_zero"}, {7'b0, intf.flag_zero}, {7'b0, ez});
`ifdef ALU_OVERFLOW_EN
        chk({name, "_ovf"}, {7'b0, intf.flag_overflow}, {7'b0, ev});
`else
        if (ev === 1'bx) n_err++;
`endif
        intf.res_ready = 1'b1;
        step();
        intf.res_ready = 1'b0;
        chk({name, "_done_ready"}, {7'b0, intf.op_ready}, 8'd1);
        chk({name, "_done_valid"}, {7'b0, intf.res_valid}, 8'd0);
    endtask

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        intf.bus_in = '0; intf.load_a = 1'b0; intf.load_b = 1'b0;
        intf.op_valid = 1'b0; intf.op_code = ADD; intf.res_ready = 1'b0;
        reset = 1'b1;
        step();
        chk("rst_result", intf.result, 8'h00);
        chk("rst_ready", {7'b0, intf.op_ready}, 8'd1);
        chk("rst_valid", {7'b0, intf.res_valid}, 8'd0);
        chk("rst_flags", {6'b0, intf.flag_carry, intf.flag_zero}, 8'd0);
        step();
        reset = 1'b0;
        step();

        load(8'h0F, 8'h01); do_op("add_0f_01", ADD, 8'h10, 1'b0, 1'b0, 1'b0);
        load(8'h05, 8'h05); do_op("sub_eq", SUB, 8'h00, 1'b1, 1'b1, 1'b0);
        load(8'h03, 8'h05); do_op("sub_borrow", SUB, 8'hFE, 1'b0, 1'b0, 1'b0);
        load(8'hFF, 8'h01); do_op("add_wrap", ADD, 8'h00, 1'b1, 1'b1, 1'b0);
        load(8'h00, 8'h00); do_op("adc_cin", ADC, 8'h01, 1'b0, 1'b0, 1'b0);
        load(8'h00, 8'h5A); do_op("pass_b", PASS_B, 8'h5A, 1'b0, 1'b0, 1'b0);
        load(8'h7F, 8'h01); do_op("add_ovf", ADD, 8'h80, 1'b0, 1'b0, 1'b1);

        // Load on the accept edge: op sees old A, the load still lands.
        load(8'h10, 8'h20);
        intf.bus_in = 8'h99; intf.load_a = 1'b1;
        do_op("same_edge_old", ADD, 8'h30, 1'b0, 1'b0, 1'b0);
        do_op("same_edge_new", ADD, 8'hB9, 1'b0, 1'b0, 1'b0);

        // Stall in HOLD with a load attempt that must be ignored.
        load(8'h40, 8'h02);
        intf.op_code = ADD; intf.op_valid = 1'b1;
        step();
        intf.op_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            intf.bus_in = 8'h77; intf.load_a = 1'b1;
            step();
            chk("hold_result", intf.result, 8'h42);
            chk("hold_valid", {7'b0, intf.res_valid}, 8'd1);
            chk("hold_ready", {7'b0, intf.op_ready}, 8'd0);
        end
        intf.load_a = 1'b0; intf.res_ready = 1'b1;
        step();
        intf.res_ready = 1'b0;
        do_op("hold_a_kept", ADD, 8'h42, 1'b0, 1'b0, 1'b0);

        // Reset pulse while a result is being held.
        load(8'h80, 8'h80);
        intf.op_code = ADD; intf.op_valid = 1'b1;
        step();
        intf.op_valid = 1'b0;
        step();
        chk("pre_rst_valid", {7'b0, intf.res_valid}, 8'd1);
        #1 reset = 1'b1;
        #1;
        chk("hold_rst_valid", {7'b0, intf.res_valid}, 8'd0);
        chk("hold_rst_result", intf.result, 8'h00);
        chk("hold_rst_ready", {7'b0, intf.op_ready}, 8'd1);
        chk("hold_rst_flags", {6'b0, intf.flag_carry, intf.flag_zero}, 8'd0);
`ifdef ALU_OVERFLOW_EN
        chk("hold_rst_ovf", {7'b0, intf.flag_overflow}, 8'd0);
`endif
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_valid", {7'b0, intf.res_valid}, 8'd0);
            chk("post_rst_ready", {7'b0, intf.op_ready}, 8'd1);
        end
        do_op("rst_operands", ADD, 8'h4D, 1'b0, 1'b0, 1'b0);

        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
